ecc_beat_packer: RTL and testbench

- Write-path stage directly upstream of ecc_encoder.
- Accepts 16-bit beats over a valid/ready handshake and assembles them into 128-bit words.
- The 128-bit word is presented lane-wise to ecc_encoder data_0..data_7 and to the buffer write port.
- Short packets (in_last before 8 beats) are zero-padded. A one-word output register lets the next word fill while the current word waits for out_ready.

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/ecc_beat_packer_if.sv | 23 ++
 rtl/ecc_out_reg.sv | 36 +++
 rtl/ecc_beat_packer.sv | 105 ++++++++++
 tb/tb_ecc_beat_packer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC write/read path (packer, encoder, decoder).
package ecc_pkg;
  localparam int LANES  = 8;
  localparam int LANE_W = 16;
  localparam int WORD_W = LANES * LANE_W;
  localparam int CODE_W = 8;
  localparam int CNT_W  = 4;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  len_t;
  typedef logic [2:0]        lane_idx_t;

  typedef struct packed {
    word_t data;
    len_t  len;
    logic  last;
  } word_pkt_t;

  // Returns w with lane idx replaced by v; lane k occupies bits [16k+15:16k].
  function automatic word_t put_lane(word_t w, lane_idx_t idx, lane_t v);
    word_t r;
    r = w;
    r[idx*LANE_W +: LANE_W] = v;
    return r;
  endfunction
endpackage

// File: rtl/ecc_beat_packer_if.sv
// Handshake bundles: 16-bit beat stream in, 128-bit lane-packed word stream out.
interface ecc_beat_if;
  import ecc_pkg::*;
  logic  valid;
  lane_t data;
  logic  last;
  logic  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

interface ecc_word_if;
  import ecc_pkg::*;
  logic  valid;
  word_t data;
  len_t  len;
  logic  last;
  logic  ready;

  modport master (output valid, output data, output len, output last, input ready);
  modport slave  (input valid, input data, input len, input last, output ready);
endinterface

// File: rtl/ecc_out_reg.sv
// Single-entry valid/ready register slice holding one {word, len, last} packet.
module ecc_out_reg
  import ecc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  word_pkt_t pkt_i,
  input  logic      ready_i,
  output logic      valid_o,
  output word_pkt_t pkt_o,
  output logic      free_o
);

  logic      valid_q;
  word_pkt_t pkt_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pkt_q   <= pkt_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // The caller only loads when free, so the held packet never changes under a stall.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

endmodule

// File: rtl/ecc_beat_packer.sv
// Packs 16-bit beats into 128-bit lane-ordered words for ecc_encoder; short packets zero-padded.
module ecc_beat_packer
  import ecc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ecc_beat_if.slave  in_if,
  ecc_word_if.master out_if
);

  lane_idx_t cnt_q, cnt_d;
  word_t     acc_q, acc_d;
  logic      acc_done_q, acc_done_d;
  len_t      held_len_q, held_len_d;
  logic      held_last_q, held_last_d;

  logic      accept;
  logic      complete;
  logic      out_free;
  logic      load;
  word_t     cur_word;
  word_pkt_t load_pkt;
  word_pkt_t out_pkt;
  logic      out_valid;

  assign in_if.ready = !acc_done_q;
  assign accept      = in_if.valid && !acc_done_q;
  assign complete    = accept && ((cnt_q == 3'd7) || in_if.last);
  assign cur_word    = put_lane(acc_q, cnt_q, in_if.data);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_done_d  = acc_done_q;
    held_len_d  = held_len_q;
    held_last_d = held_last_q;
    load        = 1'b0;
    load_pkt    = '0;

    if (acc_done_q) begin
      // HOLD: the completed word waits in acc until the output slot frees.
      if (out_free) begin
        load          = 1'b1;
        load_pkt.data = acc_q;
        load_pkt.len  = held_len_q;
        load_pkt.last = held_last_q;
        acc_d         = '0;
        acc_done_d    = 1'b0;
      end
    end else if (accept) begin
      if (complete) begin
        load_pkt.data = cur_word;
        load_pkt.len  = {1'b0, cnt_q} + len_t'(1);
        load_pkt.last = in_if.last;
        cnt_d         = '0;
        if (out_free) begin
          load  = 1'b1;
          acc_d = '0;
        end else begin
          acc_d       = cur_word;
          acc_done_d  = 1'b1;
          held_len_d  = load_pkt.len;
          held_last_d = load_pkt.last;
        end
      end else begin
        acc_d = cur_word;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      held_len_q  <= '0;
      held_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_done_q  <= acc_done_d;
      held_len_q  <= held_len_d;
      held_last_q <= held_last_d;
    end
  end

  ecc_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .pkt_i   (load_pkt),
    .ready_i (out_if.ready),
    .valid_o (out_valid),
    .pkt_o   (out_pkt),
    .free_o  (out_free)
  );

  assign out_if.valid = out_valid;
  assign out_if.data  = out_pkt.data;
  assign out_if.len   = out_pkt.len;
  assign out_if.last  = out_pkt.last;

endmodule

// File: tb/tb_ecc_beat_packer.sv
// Randomized bench for ecc_beat_packer against a packet-level word model and scoreboard.
module tb_ecc_beat_packer;
  import ecc_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_s;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   len;
    logic         last;
  } word_s;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_beat_if in_if ();
  ecc_word_if out_if ();

  ecc_beat_packer dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if),
    .out_if (out_if)
  );

  beat_s       tx_q[$];
  word_s       exp_q[$];
  logic [15:0] part_q[$];

  int           n_checks   = 0;
  int           n_fail     = 0;
  int           in_drops   = 0;
  int           words_seen = 0;
  bit           gaps       = 0;
  bit           rand_ready = 0;
  bit           stall_prev = 0;
  logic [135:0] prev_out;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Packet-level model: beats gather into a word of up to 8, zero-padded, closed by last or a full word.
  function automatic void model_beat(logic [15:0] d, logic last);
    word_s w;
    part_q.push_back(d);
    if (part_q.size() == 8 || last) begin
      w.data = '0;
      foreach (part_q[i]) w.data[i*16 +: 16] = part_q[i];
      w.len  = 4'(part_q.size());
      w.last = last;
      exp_q.push_back(w);
      part_q.delete();
    end
  endfunction

  function automatic void push_beat(logic [15:0] d, logic last);
    beat_s b;
    b.data = d;
    b.last = last;
    tx_q.push_back(b);
  endfunction

  task automatic drive();
    if (rand_ready) out_if.ready = 1'($urandom_range(1));
    if (!rst && tx_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      in_if.valid = 1'b1;
      in_if.data  = tx_q[0].data;
      in_if.last  = tx_q[0].last;
    end else begin
      in_if.valid = 1'b0;
      in_if.data  = '0;
      in_if.last  = 1'b0;
    end
  endtask

  // One clock: drive, observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    word_s w;
    beat_s b;
    drive();
    @(negedge clk);
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (in_if.valid && in_if.ready) begin
        b = tx_q.pop_front();
        model_beat(b.data, b.last);
      end
      if (stall_prev) check("hold_stable", {3'b0, out_if.len, out_if.last, out_if.data}, prev_out);
      stall_prev = out_if.valid && !out_if.ready;
      prev_out   = {3'b0, out_if.len, out_if.last, out_if.data};
      if (out_if.valid && out_if.ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("word_data", out_if.data, w.data);
          check("word_len", out_if.len, w.len);
          check("word_last", out_if.last, w.last);
        end
      end
      if (!in_if.ready) in_drops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_tx(input int budget);
    int n = 0;
    while (tx_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (tx_q.size() > 0) check("tx_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    rst          = 1'b1;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.last   = 1'b0;
    repeat (3) cycle();

    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_out_len", out_if.len, 0);
    check("rst_out_last", out_if.last, 0);
    rst = 1'b0;
    cycle();
    check("rst_in_ready", in_if.ready, 1);

    // Full word, last on the 8th beat.
    out_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_beat(16'(i), i == 8);
    run_tx(50);
    check("full_valid", out_if.valid, 1);
    check("full_data", out_if.data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("full_len", out_if.len, 8);
    check("full_last", out_if.last, 1);
    drain(20);

    // Short packet is zero-padded.
    push_beat(16'hA5A5, 1'b0);
    push_beat(16'h5A5A, 1'b0);
    push_beat(16'hFFFF, 1'b1);
    run_tx(50);
    check("short_valid", out_if.valid, 1);
    check("short_data", out_if.data, {80'h0, 48'hFFFF_5A5A_A5A5});
    check("short_len", out_if.len, 3);
    check("short_last", out_if.last, 1);
    drain(20);
    repeat (2) cycle();

    // Backpressure: one word in the out regs, one held in acc, input stalled.
    out_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) push_beat(16'($urandom), 1'b0);
    run_tx(100);
    check("bp_in_ready_low", in_if.ready, 0);
    check("bp_out_valid", out_if.valid, 1);
    repeat (3) cycle();
    check("bp_still_stalled", in_if.ready, 0);
    out_if.ready = 1'b1;
    cycle();
    check("bp_in_ready_back", in_if.ready, 1);
    check("bp_second_valid", out_if.valid, 1);
    drain(20);

    // Continuous streaming with the consumer always ready.
    in_drops   = 0;
    words_seen = 0;
    for (int i = 0; i < 64; i++) push_beat(16'($urandom), 1'b0);
    run_tx(200);
    drain(20);
    check("stream_in_drops", in_drops, 0);
    check("stream_words", words_seen, 8);

    // Reset mid-packet discards the partial word.
    for (int i = 0; i < 5; i++) push_beat(16'($urandom), 1'b0);
    run_tx(50);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", out_if.valid, 0);
    check("midrst_in_ready", in_if.ready, 1);
    words_seen = 0;
    for (int i = 0; i < 8; i++) push_beat(16'($urandom), 1'b0);
    run_tx(50);
    check("midrst_len", out_if.len, 8);
    drain(20);
    check("midrst_words", words_seen, 1);

    // Drain and completion on the same edge.
    out_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) push_beat(16'($urandom), 1'b0);
    run_tx(50);
    for (int i = 0; i < 7; i++) push_beat(16'($urandom), 1'b0);
    run_tx(50);
    check("dc_first_valid", out_if.valid, 1);
    push_beat(16'($urandom), 1'b1);
    out_if.ready = 1'b1;
    cycle();
    check("dc_valid_kept", out_if.valid, 1);
    check("dc_exp_pending", exp_q.size(), 1);
    if (exp_q.size() > 0) check("dc_new_data", out_if.data, exp_q[0].data);
    drain(20);

    // Random traffic: input gaps, random backpressure, random packet lengths.
    gaps       = 1;
    rand_ready = 1;
    for (int i = 0; i < 300; i++) push_beat(16'($urandom), i == 299 || $urandom_range(5) == 0);
    run_tx(3000);
    drain(200);
    rand_ready   = 0;
    gaps         = 0;
    out_if.ready = 1'b1;
    repeat (2) cycle();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_part_empty", part_q.size(), 0);
    check("final_idle", out_if.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
